// File: rtl/universal_shift_reg_if.sv
// Signal bundle for universal_shift_reg: controls and data toward the register, state and status back.
// No backpressure: the master drives every control each cycle and the register samples it on the edge.
interface universal_shift_reg_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
);
   logic [1:0]       mode;
   logic             ser_in_r;
   logic             ser_in_l;
   logic [WIDTH-1:0] par_in;
   logic             start;
   logic [AMT_W-1:0] amount;
   logic             rotate;
   logic [WIDTH-1:0] q;
   logic             ser_out_r;
   logic             ser_out_l;
   logic             busy;
   logic             done;

   modport master (
      output mode, ser_in_r, ser_in_l, par_in, start, amount, rotate,
      input  q, ser_out_r, ser_out_l, busy, done
   );

   modport slave (
      input  mode, ser_in_r, ser_in_l, par_in, start, amount, rotate,
      output q, ser_out_r, ser_out_l, busy, done
   );
endinterface

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register (hold/right/left/load) plus a start-triggered multi-bit shift; q updates one edge after sampling.
// No backpressure: start is only honoured in IDLE. Build option ROTATE_EN makes rotate=1 feed the outgoing bit back in.
module universal_shift_reg #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   universal_shift_reg_if.slave  bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [WIDTH-1:0] r_q;
   logic [1:0]       r_state;
   logic [AMT_W-1:0] r_cnt;
   logic             r_dir_left;
   logic             r_busy;
   logic             r_done;

   logic             w_rot;
   logic             w_fill_r;
   logic             w_fill_l;
   logic [WIDTH-1:0] w_shr;
   logic [WIDTH-1:0] w_shl;
   logic [WIDTH-1:0] w_direct;
   logic             w_shift_mode;
   logic [WIDTH-1:0] w_q_nxt;
   logic [1:0]       w_state_nxt;
   logic [AMT_W-1:0] w_cnt_nxt;
   logic             w_dir_nxt;

`ifdef ROTATE_EN
   assign w_rot = bus.rotate;
`else
   assign w_rot = 1'b0;
`endif

   // Serial inputs and rotate are sampled live on every shifting edge, including mid-sequence.
   assign w_fill_r = w_rot ? r_q[0]       : bus.ser_in_r;
   assign w_fill_l = w_rot ? r_q[WIDTH-1] : bus.ser_in_l;
   assign w_shr    = {w_fill_r, r_q[WIDTH-1:1]};
   assign w_shl    = {r_q[WIDTH-2:0], w_fill_l};

   assign w_shift_mode = (bus.mode == 2'b01) || (bus.mode == 2'b10);

   always_comb begin
      w_direct = r_q;
      case (bus.mode)
         2'b01:   w_direct = w_shr;
         2'b10:   w_direct = w_shl;
         2'b11:   w_direct = bus.par_in;
         default: w_direct = r_q;
      endcase
   end

   always_comb begin
      w_q_nxt     = r_q;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dir_nxt   = r_dir_left;
      case (r_state)
         S_IDLE: begin
            w_q_nxt = w_direct;
            if (bus.start) begin
               w_state_nxt = S_DONE;
               if (w_shift_mode && (bus.amount != '0)) begin
                  w_dir_nxt = bus.mode[1];
                  if (bus.amount != AMT_W'(1)) begin
                     w_cnt_nxt   = bus.amount - AMT_W'(1);
                     w_state_nxt = S_SHIFT;
                  end
               end else if (w_shift_mode) begin
                  // A zero-length shift degenerates to a hold that still reports done.
                  w_q_nxt = r_q;
               end
            end
         end
         S_SHIFT: begin
            w_q_nxt   = r_dir_left ? w_shl : w_shr;
            w_cnt_nxt = r_cnt - AMT_W'(1);
            if (r_cnt == AMT_W'(1)) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_q        <= '0;
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_dir_left <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_q        <= w_q_nxt;
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_dir_left <= w_dir_nxt;
         r_busy     <= (w_state_nxt == S_SHIFT);
         r_done     <= (w_state_nxt == S_DONE);
      end
   end

   assign bus.q         = r_q;
   assign bus.ser_out_r = r_q[0];
   assign bus.ser_out_l = r_q[WIDTH-1];
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg at WIDTH=8; expectations are hand-computed per scenario.
module tb_universal_shift_reg;
   logic clock;
   logic reset;
   int   errors;
   int   checks;

   universal_shift_reg_if #(.WIDTH(8), .AMT_W(4)) bus ();

   universal_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [7:0] v);
      bus.mode   = 2'b11;
      bus.par_in = v;
      tick();
      bus.mode   = 2'b00;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", bus.q); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      reset = 1'b0;
   endtask

   task automatic test_load();
      load(8'hA5);
      checks++; if (bus.q !== 8'hA5) begin errors++; $display("FAIL load_q got=%h exp=a5", bus.q); end
      checks++; if (bus.ser_out_r !== 1'b1) begin errors++; $display("FAIL load_ser_out_r got=%b exp=1", bus.ser_out_r); end
      checks++; if (bus.ser_out_l !== 1'b1) begin errors++; $display("FAIL load_ser_out_l got=%b exp=1", bus.ser_out_l); end
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL load_status busy=%b done=%b exp=0/0", bus.busy, bus.done); end
      tick();
      checks++; if (bus.q !== 8'hA5) begin errors++; $display("FAIL hold_q got=%h exp=a5", bus.q); end
   endtask

   task automatic test_direct_shift();
      bus.mode = 2'b01; bus.ser_in_r = 1'b1;
      tick();
      bus.mode = 2'b00; bus.ser_in_r = 1'b0;
      checks++; if (bus.q !== 8'hD2) begin errors++; $display("FAIL shr_q got=%h exp=d2", bus.q); end
      load(8'hA5);
      bus.mode = 2'b10; bus.ser_in_l = 1'b0;
      tick();
      bus.mode = 2'b00;
      checks++; if (bus.q !== 8'h4A) begin errors++; $display("FAIL shl_q got=%h exp=4a", bus.q); end
      checks++; if (bus.ser_out_r !== 1'b0 || bus.ser_out_l !== 1'b0) begin errors++; $display("FAIL shl_ser_out got=%b%b exp=00", bus.ser_out_l, bus.ser_out_r); end
   endtask

   task automatic test_seq_left();
      logic [7:0] exp_q [3];
      int         busy_cnt;
      int         done_cnt;
      exp_q[0] = 8'h03; exp_q[1] = 8'h07; exp_q[2] = 8'h0F;
      busy_cnt = 0; done_cnt = 0;
      load(8'h81);
      bus.start = 1'b1; bus.mode = 2'b10; bus.amount = 4'd3; bus.ser_in_l = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.start = 1'b0; bus.mode = 2'b00;
         checks++; if (bus.q !== exp_q[i]) begin errors++; $display("FAIL seq_left_q[%0d] got=%h exp=%h", i, bus.q, exp_q[i]); end
         checks++; if (bus.busy && bus.done) begin errors++; $display("FAIL seq_left_overlap[%0d] busy=1 done=1 exp not both", i); end
         if (bus.busy) busy_cnt++;
         if (bus.done) done_cnt++;
      end
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL seq_left_done_timing got=%b exp=1", bus.done); end
      tick();
      if (bus.busy) busy_cnt++;
      if (bus.done) done_cnt++;
      checks++; if (busy_cnt != 2) begin errors++; $display("FAIL seq_left_busy_cycles got=%0d exp=2", busy_cnt); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL seq_left_done_cycles got=%0d exp=1", done_cnt); end
      checks++; if (bus.q !== 8'h0F) begin errors++; $display("FAIL seq_left_final got=%h exp=0f", bus.q); end
      bus.ser_in_l = 1'b0;
   endtask

   task automatic test_amount_zero();
      load(8'h3C);
      bus.start = 1'b1; bus.mode = 2'b01; bus.amount = 4'd0; bus.ser_in_r = 1'b1;
      tick();
      bus.start = 1'b0; bus.mode = 2'b00;
      checks++; if (bus.q !== 8'h3C) begin errors++; $display("FAIL amt0_q got=%h exp=3c", bus.q); end
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin errors++; $display("FAIL amt0_status busy=%b done=%b exp=0/1", bus.busy, bus.done); end
      tick();
      checks++; if (bus.done !== 1'b0 || bus.q !== 8'h3C) begin errors++; $display("FAIL amt0_after done=%b q=%h exp=0/3c", bus.done, bus.q); end
      bus.ser_in_r = 1'b0;
   endtask

   task automatic test_mode_ignored();
      load(8'h0F);
      bus.start = 1'b1; bus.mode = 2'b01; bus.amount = 4'd3; bus.ser_in_r = 1'b0;
      tick();
      checks++; if (bus.q !== 8'h07 || bus.busy !== 1'b1) begin errors++; $display("FAIL ign_first q=%h busy=%b exp=07/1", bus.q, bus.busy); end
      bus.mode = 2'b11; bus.par_in = 8'hFF; bus.amount = 4'd9;
      tick();
      checks++; if (bus.q !== 8'h03) begin errors++; $display("FAIL ign_mid got=%h exp=03", bus.q); end
      tick();
      checks++; if (bus.q !== 8'h01 || bus.done !== 1'b1) begin errors++; $display("FAIL ign_last q=%h done=%b exp=01/1", bus.q, bus.done); end
      tick();
      checks++; if (bus.q !== 8'h01 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL ign_done_hold q=%h busy=%b done=%b exp=01/0/0", bus.q, bus.busy, bus.done); end
      bus.start = 1'b0; bus.mode = 2'b00; bus.par_in = 8'h00;
   endtask

   task automatic test_reset_abort();
      int done_cnt;
      done_cnt = 0;
      load(8'hFF);
      bus.start = 1'b1; bus.mode = 2'b01; bus.amount = 4'd10; bus.ser_in_r = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         bus.start = 1'b0; bus.mode = 2'b00;
         if (bus.done) done_cnt++;
      end
      checks++; if (bus.q !== 8'h0F || bus.busy !== 1'b1) begin errors++; $display("FAIL abort_mid q=%h busy=%b exp=0f/1", bus.q, bus.busy); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      if (bus.done) done_cnt++;
      checks++; if (bus.q !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_reset q=%h busy=%b exp=00/0", bus.q, bus.busy); end
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.done) done_cnt++;
      end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
      load(8'h5C);
      checks++; if (bus.q !== 8'h5C || bus.done !== 1'b0) begin errors++; $display("FAIL abort_reload q=%h done=%b exp=5c/0", bus.q, bus.done); end
   endtask

   task automatic test_rotate();
      logic [7:0] exp_q;
`ifdef ROTATE_EN
      exp_q = 8'h5A;
`else
      exp_q = 8'h0A;
`endif
      load(8'hA5);
      bus.rotate = 1'b1; bus.ser_in_r = 1'b0;
      bus.start = 1'b1; bus.mode = 2'b01; bus.amount = 4'd4;
      tick();
      bus.start = 1'b0; bus.mode = 2'b00;
      tick(); tick(); tick();
      checks++; if (bus.q !== exp_q || bus.done !== 1'b1) begin errors++; $display("FAIL rotate q=%h done=%b exp=%h/1", bus.q, bus.done, exp_q); end
      bus.rotate = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      load(8'h01);
      bus.start = 1'b1; bus.mode = 2'b10; bus.amount = 4'd2; bus.ser_in_l = 1'b0;
      tick();
      checks++; if (bus.q !== 8'h02 || bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_first q=%h busy=%b exp=02/1", bus.q, bus.busy); end
      bus.amount = 4'd1;
      tick();
      checks++; if (bus.q !== 8'h04 || bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done q=%h done=%b exp=04/1", bus.q, bus.done); end
      tick();
      checks++; if (bus.q !== 8'h04 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored q=%h busy=%b done=%b exp=04/0/0", bus.q, bus.busy, bus.done); end
      tick();
      bus.start = 1'b0; bus.mode = 2'b00;
      checks++; if (bus.q !== 8'h08 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_single q=%h busy=%b done=%b exp=08/0/1", bus.q, bus.busy, bus.done); end
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_end done=%b exp=0", bus.done); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      bus.mode = 2'b00; bus.ser_in_r = 1'b0; bus.ser_in_l = 1'b0;
      bus.par_in = 8'h00; bus.start = 1'b0; bus.amount = 4'd0; bus.rotate = 1'b0;
      test_reset();
      test_load();
      test_direct_shift();
      test_seq_left();
      test_amount_zero();
      test_mode_ignored();
      test_reset_abort();
      test_rotate();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised bidirectional shift register, the WIDTH-generic successor to the team's 4-bit bidirectional shift register. Supports hold, shift right, shift left and parallel load every cycle. Adds a sequenced multi-bit shift: one start pulse runs `amount` single-bit shifts back to back, with busy/done status. Sits in serial/parallel conversion datapaths between serial links and parallel buses.

## Interface
- WIDTH, 8, register width in bits (≥2)
- AMT_W, 4, width of the `amount` input
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- mode  input  2  operation select: 00 hold, 01 shift right (toward bit 0), 10 shift left (toward MSB), 11 parallel load
- ser_in_r  input  1  bit entering q[WIDTH-1] on a right shift
- ser_in_l  input  1  bit entering q[0] on a left shift
- par_in  input  WIDTH  parallel load data
- start  input  1  begin sequenced operation (sampled in IDLE only)
- amount  input  AMT_W  unsigned shift count for a sequenced shift
- rotate  input  1  rotate select (used only with ROTATE_EN)
- q  output  WIDTH  register contents
- ser_out_r  output  1  q[0], combinational from q
- ser_out_l  output  1  q[WIDTH-1], combinational from q
- busy  output  1  sequenced shift in progress
- done  output  1  one-cycle completion pulse

## Operation
- Reset: q=0, state IDLE, busy=0, done=0, internal counter=0. Reset overrides every other input, aborts any sequence, and produces no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE, start=0: mode applied directly each edge. 00 q holds. 01 q←{ser_in_r, q[WIDTH-1:1]}. 10 q←{q[WIDTH-2:0], ser_in_l}. 11 q←par_in.
- IDLE, start=1, mode 01/10, amount≥2: first shift on this edge. Direction latched, counter←amount-1, go to SHIFT.
- IDLE, start=1, mode 01/10, amount=1: one shift, go to DONE.
- IDLE, start=1, amount=0 or mode 00/11: mode applied once as in direct operation (amount=0 with a shift mode means hold), go to DONE.
- SHIFT: one shift per edge in the latched direction. Serial inputs are sampled live every edge. Counter decrements each edge. On the edge where the counter reaches 0, go to DONE. mode, start and amount are ignored.
- DONE: q holds, done=1, start ignored. Next edge returns to IDLE.
- amount > WIDTH is legal. Shifting continues, filling from the serial input.

## Timing
- Direct operations: result visible in q one edge after sampling. No latency beyond the register.
- Sequenced shift of N≥1 started at edge k: shifts occur at edges k..k+N-1.
- busy=1 for the N-1 cycles following edges k..k+N-2, and 0 for N=1.
- done=1 for exactly one cycle, following edge k+N-1.
- Earliest next start is sampled at edge k+N+1, so starts are accepted every N+1 cycles.
- busy and done are registered and never high simultaneously.
- ser_out_r and ser_out_l change only with q.

## Configuration
- ROTATE_EN defined: when rotate=1, shifts feed back the outgoing bit instead of the serial input. Right shift takes q[0]→q[WIDTH-1]; left shift takes q[WIDTH-1]→q[0]. rotate is sampled live each shift edge, including during SHIFT.
- ROTATE_EN undefined: the rotate port exists but is ignored. All shifts use ser_in_r/ser_in_l.

## Test plan
- WIDTH=8. Reset, then mode=11, par_in=8'hA5 for one edge -> q=8'hA5, ser_out_r=1, ser_out_l=1, busy=0, done=0.
- From q=8'hA5: mode=01 with ser_in_r=1 for one edge -> q=8'hD2. Reload 8'hA5, then mode=10 with ser_in_l=0 for one edge -> q=8'h4A.
- q=8'h81, start=1, mode=10, amount=3, ser_in_l=1 -> q=03, 07, 0F on consecutive edges; busy high 2 cycles; done high 1 cycle; then IDLE with q=8'h0F.
- q=8'h3C, start=1, mode=01, amount=0 -> q stays 8'h3C, busy never high, done pulses the next cycle. mode changes during SHIFT of another sequence have no effect.
- Start a sequenced shift with amount=10, assert reset after 4 edges -> q=0, busy=0 next cycle, done never pulses; a direct load works on the following edge.
- ROTATE_EN defined, q=8'hA5, rotate=1, start, mode=01, amount=4 -> q=8'h5A. Same stimulus without ROTATE_EN and ser_in_r=0 -> q=8'h0A.
